hazard3_tick_gen: RTL and testbench
===================================

HAZARD3_TICK_GEN -- requirements
Module: hazard3_tick_gen

Interface
REQ-001 SHALL have parameter DIV_RESET, default 16'd1: reset value of DIV.INT.
REQ-002 SHALL have port clk  input  1  sole clock; all state on posedge clk.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port paddr  input  16  APB address (byte).
REQ-005 SHALL have port psel  input  1  APB select.
REQ-006 SHALL have port penable  input  1  APB enable (access phase).
REQ-007 SHALL have port pwrite  input  1  APB write strobe.
REQ-008 SHALL have port pwdata  input  32  APB write data.
REQ-009 SHALL have port prdata  output  32  APB read data, combinational decode of paddr.
REQ-010 SHALL have port pready  output  1  tied 1.
REQ-011 SHALL have port pslverr  output  1  tied 0.
REQ-012 SHALL have port tick  output  1  registered tick to the RISC-V timer (pulse or NRZ mode).

Function
REQ-013 SHALL treat an access as a write when psel && penable && pwrite, and as a read when psel && penable && !pwrite.
REQ-014 SHALL map CTRL at 0x00: bit0 EN, bit1 NRZ; other bits read 0 and are ignored on write.
REQ-015 SHALL map DIV at 0x04: bits[15:0] INT, bits[23:16] FRAC; bits[31:24] read 0.
REQ-016 SHALL map COUNT at 0x08, read-only: bits[15:0] current cycle counter ctr; writes ignored.
REQ-017 SHALL map TICKS at 0x0C: 32-bit count of tick events, wrapping 0xFFFFFFFF->0; a write loads pwdata.
REQ-018 SHALL return 0 on reads of unmapped addresses and ignore writes to them.
REQ-019 SHALL compute period P = max(INT,1) + stretch, where stretch is a 1-bit register; INT=0 behaves as INT=1.
REQ-020 SHALL, while EN=1, increment ctr each cycle and, when ctr==P-1, raise event: ctr<=0, TICKS<=TICKS+1.
REQ-021 SHALL on each event compute {carry,acc}=acc+FRAC (9-bit), load the 8-bit remainder into acc, and set stretch<=carry.
REQ-022 SHALL in pulse mode (NRZ=0) register tick<=event, i.e. tick high exactly one cycle per event, or continuously high when P=1.
REQ-023 SHALL in NRZ mode (NRZ=1) register tick<=tick^event, i.e. one toggle per event.
REQ-024 SHALL, after the write setting EN completes at edge E0 with stretch=0, assert the first event-driven tick change at edge E0+max(INT,1).
REQ-025 SHALL, while EN=0, hold ctr=0, acc=0, stretch=0, TICKS unchanged; pulse-mode tick=0; NRZ-mode tick holds its level.
REQ-026 SHALL, on a DIV write, clear ctr, acc and stretch and suppress any event in that cycle.
REQ-027 SHALL, on a CTRL write that changes NRZ, clear tick to 0 in the following cycle and suppress any event in that cycle.
REQ-028 SHALL, on a TICKS write coinciding with an event, load pwdata and not count that event.
REQ-029 SHALL never produce an event in a cycle where EN=0, including the cycle in which EN is written 0.

Reset
REQ-030 SHALL asynchronously set EN=0, NRZ=0, INT=DIV_RESET, FRAC=0, ctr=0, acc=0, stretch=0, TICKS=0, tick=0 when rst_n low.
REQ-031 SHALL, on reset mid-period, abandon the period; the first tick after release follows REQ-024 from the next EN write.

Verification
REQ-032 SHALL cover: DIV=0x0004, write CTRL=1 at E0 -> tick high one cycle at E0+4, E0+8, E0+12; TICKS=3 after E0+12.
REQ-033 SHALL cover: DIV=0x00800002, EN=1 -> tick periods 2,2,3,2,3 cycles; acc read-back via period pattern only.
REQ-034 SHALL cover: DIV=0, EN=1 -> tick continuously high from E0+1; CTRL=3 with DIV=1 -> tick toggles every cycle.
REQ-035 SHALL cover: DIV write in the same cycle ctr==P-1 -> no tick, COUNT reads 0 next cycle, TICKS unchanged.
REQ-036 SHALL cover: TICKS=0xFFFFFFFF, one event -> TICKS=0; TICKS write coincident with event -> TICKS=written value.
REQ-037 SHALL cover: rst_n asserted mid-period with NRZ tick=1 -> tick=0, all registers at reset values, no tick until EN rewritten.

Source files
------------

// File: rtl/hazard3_tick_gen_if.sv
// APB3 slave bundle for the timer tick generator register block.
// A transfer is valid in the cycle where psel && penable are both high; pready is
// always 1, so every transfer completes in that same cycle and pwrite selects direction.
interface hazard3_tick_gen_if;
  logic [15:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/hazard3_tick_gen.sv
// Fractional clock divider producing the RISC-V machine timer tick, with an APB
// register block for enable/mode (CTRL), divisor (DIV), live counter and event count.
module hazard3_tick_gen #(
  parameter logic [15:0] DIV_RESET = 16'd1
) (
  input  logic              clk,
  input  logic              rst_n,
  hazard3_tick_gen_if.slave apb,
  output logic              tick
);
  localparam logic [15:0] ADDR_CTRL  = 16'h0000;
  localparam logic [15:0] ADDR_DIV   = 16'h0004;
  localparam logic [15:0] ADDR_COUNT = 16'h0008;
  localparam logic [15:0] ADDR_TICKS = 16'h000c;

  logic        en;
  logic        nrz;
  logic [15:0] div_int;
  logic [7:0]  div_frac;
  logic [15:0] ctr;
  logic [7:0]  acc;
  logic        stretch;
  logic [31:0] ticks;

  logic        wr;
  logic        wr_ctrl;
  logic        wr_div;
  logic        wr_ticks;
  logic        en_drop;
  logic        nrz_change;
  logic        period_end;
  logic        event_fire;
  logic [16:0] period;
  logic [8:0]  acc_sum;
  logic [31:0] rdata;

  always_comb begin
    wr         = apb.psel && apb.penable && apb.pwrite;
    wr_ctrl    = wr && (apb.paddr == ADDR_CTRL);
    wr_div     = wr && (apb.paddr == ADDR_DIV);
    wr_ticks   = wr && (apb.paddr == ADDR_TICKS);
    en_drop    = wr_ctrl && !apb.pwdata[0];
    nrz_change = wr_ctrl && (apb.pwdata[1] != nrz);
    // INT=0 is treated as a divide-by-one; stretch adds the fractional extra cycle.
    period     = ((div_int == 16'd0) ? 17'd1 : {1'b0, div_int}) + {16'd0, stretch};
    period_end = en && ({1'b0, ctr} == (period - 17'd1));
    event_fire = period_end && !wr_div && !nrz_change && !en_drop;
    acc_sum    = {1'b0, acc} + {1'b0, div_frac};
  end

  always_comb begin
    rdata = 32'd0;
    case (apb.paddr)
      ADDR_CTRL:  rdata = {30'd0, nrz, en};
      ADDR_DIV:   rdata = {8'd0, div_frac, div_int};
      ADDR_COUNT: rdata = {16'd0, ctr};
      ADDR_TICKS: rdata = ticks;
      default:    rdata = 32'd0;
    endcase
  end

  assign apb.prdata  = rdata;
  assign apb.pready  = 1'b1;
  assign apb.pslverr = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en       <= 1'b0;
      nrz      <= 1'b0;
      div_int  <= DIV_RESET;
      div_frac <= 8'd0;
    end else begin
      if (wr_ctrl) begin
        en  <= apb.pwdata[0];
        nrz <= apb.pwdata[1];
      end
      if (wr_div) begin
        div_int  <= apb.pwdata[15:0];
        div_frac <= apb.pwdata[23:16];
      end
    end
  end

  // The counter wraps at period end even when the event itself is suppressed,
  // so a suppressed period never leaves ctr past P-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr     <= 16'd0;
      acc     <= 8'd0;
      stretch <= 1'b0;
    end else if (!en || wr_div) begin
      ctr     <= 16'd0;
      acc     <= 8'd0;
      stretch <= 1'b0;
    end else begin
      ctr <= period_end ? 16'd0 : (ctr + 16'd1);
      if (event_fire) begin
        acc     <= acc_sum[7:0];
        stretch <= acc_sum[8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ticks <= 32'd0;
    end else if (wr_ticks) begin
      ticks <= apb.pwdata;
    end else if (event_fire) begin
      ticks <= ticks + 32'd1;
    end
  end

  // A mode switch restarts the output from a known low level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick <= 1'b0;
    end else if (nrz_change) begin
      tick <= 1'b0;
    end else if (nrz) begin
      tick <= tick ^ event_fire;
    end else begin
      tick <= event_fire;
    end
  end
endmodule

// File: tb/tb_hazard3_tick_gen.sv
// Directed bench for hazard3_tick_gen: APB driver tasks push expected read data and
// per-cycle tick levels into queues that an independent negedge monitor pops and checks.
module tb_hazard3_tick_gen;
  localparam logic [15:0] A_CTRL  = 16'h0000;
  localparam logic [15:0] A_DIV   = 16'h0004;
  localparam logic [15:0] A_COUNT = 16'h0008;
  localparam logic [15:0] A_TICKS = 16'h000c;
  localparam logic [15:0] A_NONE  = 16'h0010;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] exp_q[$];
  logic [15:0] addr_q[$];
  logic [0:0]  tick_q[$];

  hazard3_tick_gen_if bus();

  hazard3_tick_gen #(.DIV_RESET(16'd1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .apb   (bus.slave),
    .tick  (tick)
  );

  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic apb_write(input logic [15:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.paddr   = a;
    bus.pwdata  = d;
    bus.pwrite  = 1'b1;
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    @(posedge clk); #1;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
  endtask

  task automatic apb_read(input logic [15:0] a, input logic [31:0] e);
    @(posedge clk); #1;
    bus.paddr   = a;
    bus.pwrite  = 1'b0;
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    exp_q.push_back(e);
    addr_q.push_back(a);
    @(posedge clk); #1;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Entry k of pat is the tick level expected after the k-th rising edge from now.
  task automatic push_ticks(input int n, input logic [63:0] pat);
    for (int i = 0; i < n; i++) tick_q.push_back(pat[i]);
  endtask

  task automatic expect_ticks(input int n, input logic [63:0] pat);
    push_ticks(n, pat);
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic settle();
    int n;
    n = 0;
    while (tick_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tick_q.size() != 0) begin
      errors++;
      $display("FAIL settle: tick queue still holds %0d entries, required 0", tick_q.size());
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [31:0] e;
    logic [15:0] a;
    logic [0:0]  te;
    cyc++;
    if (bus.psel && bus.penable && !bus.pwrite) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL read: unexpected access addr=0x%h got=0x%h", bus.paddr, bus.prdata);
      end else begin
        e = exp_q.pop_front();
        a = addr_q.pop_front();
        if (bus.prdata !== e) begin
          errors++;
          $display("FAIL read addr=0x%h: got=0x%h required=0x%h", a, bus.prdata, e);
        end
      end
      checks++;
      if (bus.pready !== 1'b1 || bus.pslverr !== 1'b0) begin
        errors++;
        $display("FAIL pready/pslverr: got=%b/%b required=1/0", bus.pready, bus.pslverr);
      end
    end
    if (tick_q.size() != 0) begin
      te = tick_q.pop_front();
      checks++;
      if (tick !== te[0]) begin
        errors++;
        $display("FAIL tick cycle=%0d: got=%b required=%b", cyc, tick, te[0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.paddr   = 16'd0;
    bus.pwdata  = 32'd0;
    bus.pwrite  = 1'b0;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    push_ticks(2, 64'h0);
    idle(3);
    #2 rst_n = 1'b1;

    // Reset values, unmapped and read-only behaviour
    apb_read(A_CTRL, 32'h0);
    apb_read(A_DIV, 32'h0000_0001);
    apb_read(A_COUNT, 32'h0);
    apb_read(A_TICKS, 32'h0);
    apb_read(A_NONE, 32'h0);
    apb_write(A_COUNT, 32'h0000_1234);
    apb_write(A_NONE, 32'hffff_ffff);
    apb_write(A_CTRL, 32'hffff_fffc);
    apb_read(A_COUNT, 32'h0);
    apb_read(A_NONE, 32'h0);
    apb_read(A_CTRL, 32'h0);

    // Integer divide by 4: ticks at E0+4, +8, +12
    apb_write(A_DIV, 32'h0000_0004);
    apb_write(A_CTRL, 32'h1);
    expect_ticks(14, 64'h1110);
    apb_read(A_TICKS, 32'd3);

    // Fractional divide 2.5: periods 2,2,3,2,3; DIV upper byte reads 0
    apb_write(A_CTRL, 32'h0);
    apb_write(A_DIV, 32'hff12_3456);
    apb_read(A_DIV, 32'h0012_3456);
    apb_write(A_DIV, 32'h0080_0002);
    apb_read(A_DIV, 32'h0080_0002);
    apb_write(A_CTRL, 32'h1);
    expect_ticks(14, 64'h1294);

    // DIV=0 behaves as 1: tick stays high from E0+1
    apb_write(A_CTRL, 32'h0);
    apb_write(A_DIV, 32'h0);
    apb_write(A_CTRL, 32'h1);
    expect_ticks(6, 64'h3e);
    apb_read(A_DIV, 32'h0);

    // NRZ with DIV=1: toggles every cycle
    apb_write(A_CTRL, 32'h0);
    apb_write(A_DIV, 32'h1);
    apb_write(A_CTRL, 32'h3);
    push_ticks(8, 64'haa);
    apb_read(A_CTRL, 32'h3);
    settle();

    // DIV write landing on ctr==P-1 suppresses the event and restarts the count
    apb_write(A_CTRL, 32'h0);
    apb_write(A_TICKS, 32'h0);
    apb_write(A_DIV, 32'h4);
    apb_write(A_CTRL, 32'h1);
    idle(1);
    apb_write(A_DIV, 32'h6);
    push_ticks(8, 64'h40);
    apb_read(A_COUNT, 32'd2);
    apb_read(A_TICKS, 32'd0);
    settle();

    // TICKS wrap, then a TICKS write coincident with an event wins
    apb_write(A_CTRL, 32'h0);
    apb_write(A_DIV, 32'h4);
    apb_write(A_TICKS, 32'hffff_ffff);
    apb_write(A_CTRL, 32'h1);
    push_ticks(10, 64'h110);
    idle(2);
    apb_read(A_TICKS, 32'h0);
    apb_write(A_TICKS, 32'h1234_5678);
    apb_read(A_TICKS, 32'h1234_5678);
    settle();

    // Reset mid-period with NRZ tick high
    apb_write(A_CTRL, 32'h0);
    apb_write(A_CTRL, 32'h2);
    apb_write(A_CTRL, 32'h3);
    push_ticks(5, 64'h10);
    idle(5);
    #2 rst_n = 1'b0;
    push_ticks(3, 64'h0);
    idle(3);
    #2 rst_n = 1'b1;
    push_ticks(10, 64'h0);
    apb_read(A_CTRL, 32'h0);
    apb_read(A_DIV, 32'h0000_0001);
    apb_read(A_COUNT, 32'h0);
    apb_read(A_TICKS, 32'h0);
    settle();
    apb_write(A_CTRL, 32'h1);
    expect_ticks(4, 64'he);

    idle(4);
    checks++;
    if (exp_q.size() != 0 || tick_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got read=%0d tick=%0d pending, required 0/0", exp_q.size(), tick_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
